io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, FIFO depth in entries, power of two, 2 to 16.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 io_rd  input  1  CPU read strobe (RD from control decode); one access per high clk cycle.
REQ-005 io_wr  input  1  CPU write strobe (WR from control decode).
REQ-006 io_addr  input  8  port select (SIG from control decode); only bits [1:0] are decoded.
REQ-007 io_wdata  input  8  CPU write data.
REQ-008 io_rdata  output  8  read data; combinational from registered state and io_addr.
REQ-009 in_valid, in_data[7:0]  input  1/8  external producer into the input FIFO.
REQ-010 in_ready  output  1  input FIFO not full.
REQ-011 out_valid, out_data[7:0]  output  1/8  output FIFO head toward the external consumer.
REQ-012 out_ready  input  1  external consumer accepts the head.
REQ-013 gpio_in  input  8  asynchronous pins; gpio_out  output  8  registered pins.
REQ-014 cli  input  1  clear-interrupt (CLI decode); irq  output  1  interrupt request (see Configuration).

Function
REQ-015 Port map: addr 0 data; 1 status; 2 gpio_out; 3 gpio_in.
REQ-016 Read of port 0 when the input FIFO is non-empty SHALL return the head and pop it at the clock edge ending the strobe cycle.
REQ-017 Read of port 0 when the input FIFO is empty SHALL return 0x00 and change no state.
REQ-018 Write of port 0 SHALL push io_wdata into the output FIFO; if full, the data SHALL be dropped and status bit4 (out_ovf) set sticky.
REQ-019 Status read SHALL be {3'b0, out_ovf, in_ovf, irq_pend, out_full, in_nonempty}, bits 7..0.
REQ-020 Write of port 1 SHALL clear each sticky bit in_ovf/out_ovf whose io_wdata bit is 1 (write-1-to-clear).
REQ-021 Port 2 SHALL be read/write and drive gpio_out; port 3 SHALL be read-only, returning gpio_in after a 2-flop synchronizer; writes to port 3 SHALL be ignored.
REQ-022 An external push SHALL occur when in_valid and in_ready are both high; in_ready SHALL be !full, evaluated before any same-cycle pop.
REQ-023 in_valid high while the input FIFO is full SHALL set in_ovf; the data SHALL be discarded.
REQ-024 out_valid SHALL be !empty; a pop SHALL occur when out_valid and out_ready are both high; out_data SHALL be stable while out_valid is high and out_ready is low.
REQ-025 A same-cycle push and pop on one FIFO SHALL both take effect, leaving the count unchanged.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; the count SHALL span 0..DEPTH.
REQ-027 io_rd and io_wr high together SHALL perform the read side-effects only; the write SHALL be suppressed.
REQ-028 FIFO and port latency: a CPU write is visible on out_valid the next cycle; an external push is readable on port 0 the next cycle.

Reset
REQ-029 Reset SHALL empty both FIFOs and clear in_ovf, out_ovf, irq_pend, gpio_out, and the synchronizer flops.
REQ-030 During reset, outputs SHALL be in_ready=1, out_valid=0, irq=0, gpio_out=0x00, io_rdata=0x00.
REQ-031 Reset asserted mid-transfer SHALL discard all in-flight data; the first edge after deassertion SHALL behave as from empty.

Configuration
REQ-032 With IO_RESPONDER_IRQ_EN defined, irq_pend SHALL set on any cycle in which the input FIFO goes from empty to non-empty, and clear on cli.
REQ-033 With IO_RESPONDER_IRQ_EN defined, cli and a new set in the same cycle SHALL leave irq_pend set; irq SHALL equal irq_pend.
REQ-034 Without IO_RESPONDER_IRQ_EN, irq SHALL be constant 0, status bit2 SHALL read 0, and cli SHALL be ignored.

Structure
REQ-035 Port addresses, status bit positions, and the data width constant SHALL live in shared package io_pkg.
REQ-036 The FIFO SHALL be the sub-module io_fifo (WIDTH, DEPTH), instantiated twice.

Verification
REQ-037 Push 0x11, 0x22, 0x33 externally; CPU read port 0 three times -> 0x11, 0x22, 0x33; fourth read -> 0x00; status bit0 = 0.
REQ-038 CPU write 0xA0..0xA4 (5 writes, DEPTH=4) with out_ready=0 -> status = 0x12; then out_ready=1 -> A0, A1, A2, A3 delivered; write port 1 with 0x10 -> status = 0x00.
REQ-039 Input FIFO full, in_valid=1 and CPU pop in the same cycle -> in_ready=0, data dropped, in_ovf=1, count goes 4 -> 3.
REQ-040 With IO_RESPONDER_IRQ_EN defined: single push -> irq high next cycle; cli -> irq low; cli coincident with empty-to-non-empty -> irq stays high.
REQ-041 Write 0x5A to port 2 -> gpio_out = 0x5A; drive gpio_in = 0xC3 -> port 3 reads 0xC3 from the 3rd cycle on; rst pulse mid-stream -> all reset values of REQ-030.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the IO responder: data width, port map and
// status register bit positions.
package io_pkg;

   localparam int DW = 8;

   typedef enum logic [1:0] {
      P_DATA = 2'd0,
      P_STAT = 2'd1,
      P_GPO  = 2'd2,
      P_GPI  = 2'd3
   } port_e;

   localparam int ST_IN_NE    = 0;
   localparam int ST_OUT_FULL = 1;
   localparam int ST_IRQ      = 2;
   localparam int ST_IN_OVF   = 3;
   localparam int ST_OUT_OVF  = 4;

endpackage

// File: rtl/io_responder_if.sv
// CPU port bus plus the input/output byte streams of the IO responder.
// master drives requests and stream data; slave is the responder.
interface io_responder_if;
   import io_pkg::*;

   logic          io_rd;
   logic          io_wr;
   logic [DW-1:0] io_addr;
   logic [DW-1:0] io_wdata;
   logic [DW-1:0] io_rdata;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;

   modport master (
      output io_rd, io_wr, io_addr, io_wdata,
      output in_valid, in_data, out_ready,
      input  io_rdata, in_ready, out_valid, out_data
   );

   modport slave (
      input  io_rd, io_wr, io_addr, io_wdata,
      input  in_valid, in_data, out_ready,
      output io_rdata, in_ready, out_valid, out_data
   );

endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO; push is refused when full and pop when empty, both
// judged on the count before this edge.
module io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   typedef logic [AW:0] cnt_t;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   cnt_t             r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == cnt_t'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_rdata = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_cnt <= r_cnt + cnt_t'(w_push) - cnt_t'(w_pop);
      end
   end

endmodule

// File: rtl/io_responder.sv
// Four-port CPU IO responder: byte FIFOs in/out, status, GPIO.
// Define IO_RESPONDER_IRQ_EN to enable the input-arrival interrupt.
module io_responder
   import io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   io_responder_if.slave bus,
   input  logic [DW-1:0] gpio_in,
   output logic [DW-1:0] gpio_out,
   input  logic          cli,
   output logic          irq
);

   port_e         w_port;
   logic          w_rd;
   logic          w_wr;
   logic          w_in_push;
   logic          w_in_pop;
   logic          w_in_full;
   logic          w_in_empty;
   logic [DW-1:0] w_in_head;
   logic          w_out_push;
   logic          w_out_full;
   logic          w_out_empty;
   logic          w_stat_wr;
   logic          w_irq_pend;
   logic [DW-1:0] w_status;
   logic [DW-1:0] w_rdata;
   logic          w_unused;

   logic          r_in_ovf;
   logic          r_out_ovf;
   logic [DW-1:0] r_gpio_out;
   logic [DW-1:0] r_sync1;
   logic [DW-1:0] r_sync2;

   // A read wins over a coincident write.
   assign w_port     = port_e'(bus.io_addr[1:0]);
   assign w_rd       = bus.io_rd;
   assign w_wr       = bus.io_wr & ~bus.io_rd;
   assign w_in_push  = bus.in_valid & ~w_in_full;
   assign w_in_pop   = w_rd & (w_port == P_DATA);
   assign w_out_push = w_wr & (w_port == P_DATA);
   assign w_stat_wr  = w_wr & (w_port == P_STAT);

   io_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_in_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (bus.in_valid),
      .i_wdata (bus.in_data),
      .i_pop   (w_in_pop),
      .o_rdata (w_in_head),
      .o_full  (w_in_full),
      .o_empty (w_in_empty)
   );

   io_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_out_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_out_push),
      .i_wdata (bus.io_wdata),
      .i_pop   (bus.out_ready),
      .o_rdata (bus.out_data),
      .o_full  (w_out_full),
      .o_empty (w_out_empty)
   );

   assign bus.in_ready  = ~w_in_full;
   assign bus.out_valid = ~w_out_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_ovf   <= 1'b0;
         r_out_ovf  <= 1'b0;
         r_gpio_out <= '0;
         r_sync1    <= '0;
         r_sync2    <= '0;
      end else begin
         r_sync1 <= gpio_in;
         r_sync2 <= r_sync1;
         if (w_wr && (w_port == P_GPO)) r_gpio_out <= bus.io_wdata;
         r_in_ovf  <= (bus.in_valid & w_in_full) |
                      (r_in_ovf & ~(w_stat_wr & bus.io_wdata[ST_IN_OVF]));
         r_out_ovf <= (w_out_push & w_out_full) |
                      (r_out_ovf & ~(w_stat_wr & bus.io_wdata[ST_OUT_OVF]));
      end
   end

`ifdef IO_RESPONDER_IRQ_EN
   logic r_irq_pend;

   // A fresh arrival outranks a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_irq_pend <= 1'b0;
      else     r_irq_pend <= (w_in_empty & w_in_push) | (r_irq_pend & ~cli);
   end

   assign w_irq_pend = r_irq_pend;
`else
   assign w_irq_pend = 1'b0;
`endif

   always_comb begin
      w_status              = '0;
      w_status[ST_IN_NE]    = ~w_in_empty;
      w_status[ST_OUT_FULL] = w_out_full;
      w_status[ST_IRQ]      = w_irq_pend;
      w_status[ST_IN_OVF]   = r_in_ovf;
      w_status[ST_OUT_OVF]  = r_out_ovf;
   end

   always_comb begin
      w_rdata = '0;
      unique case (w_port)
         P_DATA: if (!w_in_empty) w_rdata = w_in_head;
         P_STAT: w_rdata = w_status;
         P_GPO:  w_rdata = r_gpio_out;
         P_GPI:  w_rdata = r_sync2;
      endcase
   end

   assign bus.io_rdata = w_rdata;
   assign gpio_out     = r_gpio_out;
   assign irq          = w_irq_pend;
   assign w_unused     = ^{bus.io_addr[DW-1:2], cli};

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: FIFOs, status, GPIO, reset, and the
// interrupt path (expectations follow IO_RESPONDER_IRQ_EN).
module tb_io_responder;
   import io_pkg::*;

`ifdef IO_RESPONDER_IRQ_EN
   localparam logic [7:0] IRQB = 8'h04;
   localparam logic [7:0] IRQ1 = 8'h01;
`else
   localparam logic [7:0] IRQB = 8'h00;
   localparam logic [7:0] IRQ1 = 8'h00;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out;
   logic       cli;
   logic       irq;
   int         n_tests = 0;
   int         n_fail  = 0;

   io_responder_if bus();

   io_responder #(.DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .cli      (cli),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      bus.io_rd    = 1'b0;
      bus.io_wr    = 1'b0;
      bus.in_valid = 1'b0;
      cli          = 1'b0;
   endtask

   task automatic peek(input string tag, input logic [7:0] a,
                       input logic [7:0] exp);
      bus.io_rd   = 1'b0;
      bus.io_addr = a;
      #1;
      chk(tag, bus.io_rdata, exp);
   endtask

   task automatic pop(input string tag, input logic [7:0] exp);
      bus.io_rd   = 1'b1;
      bus.io_addr = 8'h00;
      #1;
      chk(tag, bus.io_rdata, exp);
      tick();
      bus.io_rd = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus.io_wr    = 1'b1;
      bus.io_addr  = a;
      bus.io_wdata = d;
      tick();
      bus.io_wr = 1'b0;
   endtask

   task automatic push_in(input logic [7:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      idle();
      gpio_in       = 8'h00;
      bus.out_ready = 1'b0;
      bus.io_addr   = 8'h00;
      bus.io_wdata  = 8'h00;
      bus.in_data   = 8'h00;
      repeat (2) tick();

      chk("rst_in_ready", 8'(bus.in_ready), 8'h01);
      chk("rst_out_valid", 8'(bus.out_valid), 8'h00);
      chk("rst_irq", 8'(irq), 8'h00);
      chk("rst_gpio_out", gpio_out, 8'h00);
      for (int a = 0; a < 4; a++)
         peek($sformatf("rst_rdata%0d", a), 8'(a), 8'h00);
      rst = 1'b0;
      tick();

      // input FIFO read-back
      push_in(8'h11);
      peek("in_latency", 8'h00, 8'h11);
      push_in(8'h22);
      push_in(8'h33);
      peek("in_status", 8'h01, 8'h01 | IRQB);
      chk("in_irq", 8'(irq), IRQ1);
      pop("pop0", 8'h11);
      pop("pop1", 8'h22);
      pop("pop2", 8'h33);
      pop("pop_empty", 8'h00);
      peek("empty_status", 8'h01, IRQB);
      cli = 1'b1;
      tick();
      cli = 1'b0;
      chk("cli_irq", 8'(irq), 8'h00);
      peek("clr_status", 8'h01, 8'h00);

      // output FIFO overflow and drain
      bus.io_wr    = 1'b1;
      bus.io_addr  = 8'h00;
      bus.io_wdata = 8'hA0;
      tick();
      chk("out_latency_v", 8'(bus.out_valid), 8'h01);
      chk("out_latency_d", bus.out_data, 8'hA0);
      for (int i = 1; i < 5; i++) begin
         bus.io_wdata = 8'(8'hA0 + i);
         tick();
      end
      bus.io_wr = 1'b0;
      peek("ovf_status", 8'h01, 8'h12);
      chk("out_hold", bus.out_data, 8'hA0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain_v%0d", i), 8'(bus.out_valid), 8'h01);
         chk($sformatf("drain_d%0d", i), bus.out_data, 8'(8'hA0 + i));
         tick();
      end
      bus.out_ready = 1'b0;
      chk("drained", 8'(bus.out_valid), 8'h00);
      wr(8'h01, 8'h10);
      peek("w1c_status", 8'h01, 8'h00);

      // full input FIFO with concurrent push attempt and pop
      for (int i = 0; i < 4; i++) push_in(8'(8'hB0 + i));
      chk("full_ready", 8'(bus.in_ready), 8'h00);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      bus.io_rd    = 1'b1;
      bus.io_addr  = 8'h00;
      #1;
      chk("full_ready2", 8'(bus.in_ready), 8'h00);
      chk("full_head", bus.io_rdata, 8'hB0);
      tick();
      idle();
      chk("cnt3_ready", 8'(bus.in_ready), 8'h01);
      peek("in_ovf_status", 8'h01, 8'h09 | IRQB);
      pop("full_pop1", 8'hB1);
      pop("full_pop2", 8'hB2);
      pop("full_pop3", 8'hB3);
      pop("full_dropped", 8'h00);
      wr(8'h01, 8'h08);
      cli = 1'b1;
      tick();
      cli = 1'b0;
      peek("ovf_clr", 8'h01, 8'h00);

      // interrupt path
      push_in(8'h77);
      chk("irq_set", 8'(irq), IRQ1);
      cli = 1'b1;
      tick();
      cli = 1'b0;
      chk("irq_cli", 8'(irq), 8'h00);
      pop("irq_pop", 8'h77);
      cli          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h88;
      tick();
      idle();
      chk("irq_coincide", 8'(irq), IRQ1);
      peek("irq_status", 8'h01, 8'h01 | IRQB);
      pop("irq_pop2", 8'h88);
      cli = 1'b1;
      tick();
      cli = 1'b0;

      // GPIO and read/write collision
      wr(8'h02, 8'h5A);
      chk("gpo", gpio_out, 8'h5A);
      peek("gpo_rd", 8'h02, 8'h5A);
      wr(8'h03, 8'hFF);
      chk("gpi_wr_ign", gpio_out, 8'h5A);
      bus.io_rd    = 1'b1;
      bus.io_wr    = 1'b1;
      bus.io_addr  = 8'h02;
      bus.io_wdata = 8'h00;
      tick();
      bus.io_addr  = 8'h00;
      bus.io_wdata = 8'h99;
      tick();
      idle();
      chk("rdwr_gpo", gpio_out, 8'h5A);
      chk("rdwr_out", 8'(bus.out_valid), 8'h00);
      gpio_in = 8'hC3;
      peek("gpi_c1", 8'h03, 8'h00);
      tick();
      peek("gpi_c2", 8'h03, 8'h00);
      tick();
      peek("gpi_c3", 8'h03, 8'hC3);

      // reset in the middle of traffic
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h21;
      bus.io_wr    = 1'b1;
      bus.io_addr  = 8'h00;
      bus.io_wdata = 8'h31;
      tick();
      #1;
      rst = 1'b1;
      idle();
      #1;
      chk("mid_in_ready", 8'(bus.in_ready), 8'h01);
      chk("mid_out_valid", 8'(bus.out_valid), 8'h00);
      chk("mid_irq", 8'(irq), 8'h00);
      chk("mid_gpio_out", gpio_out, 8'h00);
      for (int a = 0; a < 4; a++)
         peek($sformatf("mid_rdata%0d", a), 8'(a), 8'h00);
      tick();
      tick();
      rst = 1'b0;
      push_in(8'h42);
      peek("post_status", 8'h01, 8'h01 | IRQB);
      pop("post_pop", 8'h42);
      pop("post_empty", 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
